// File: rtl/dllp_extractor_if.sv
// dllp_extractor_if: beat input handshake plus the DLLP output bundle for dllp_extractor.
interface dllp_extractor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [511:0]         data_in;
    logic [63:0]          pl_valid;
    logic [63:0]          pl_dlpstart;
    logic [63:0]          pl_dlpend;
    logic [47:0]          dllp_data;
    logic                 dllp_valid;
    logic                 dllp_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid, data_in, pl_valid, pl_dlpstart, pl_dlpend,
        input  in_ready, dllp_data, dllp_valid, dllp_err, err_cnt
    );

    modport slave (
        input  in_valid, data_in, pl_valid, pl_dlpstart, pl_dlpend,
        output in_ready, dllp_data, dllp_valid, dllp_err, err_cnt
    );
endinterface

// File: rtl/dllp_extractor.sv
// dllp_extractor: pulls 8-byte DLLPs (SDP, 6 payload bytes, END) out of 64-byte beats,
// one per cycle, carrying a DLLP that straddles the beat boundary into the next beat.
module dllp_extractor #(
    parameter int ERR_CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    input logic linkup,
    dllp_extractor_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;
    state_t               state;
    logic [511:0]         data_q;
    logic [63:0]          vld_q, end_q, pend;
    logic [47:0]          carry, win, c_data, p_data, dllp_data;
    logic [2:0]           carry_cnt, c_idx;
    logic [5:0]           s;
    logic                 carry_pend, p_valid, p_err, dllp_valid, dllp_err;
    logic                 hit, end_ok, c_ok;
    logic [ERR_CNT_W-1:0] err_cnt;

    assign bus.in_ready   = linkup & (state == IDLE);
    assign bus.dllp_data  = dllp_data;
    assign bus.dllp_valid = dllp_valid;
    assign bus.dllp_err   = dllp_err;
    assign bus.err_cnt    = err_cnt;

    always_comb begin
        s   = '0;
        hit = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (pend[i]) begin
                s   = 6'(i);
                hit = 1'b1;
            end
        end
        win    = 48'(data_q >> {({1'b0, s} + 7'd1), 3'b000});
        end_ok = (s <= 6'd56) & end_q[s + 6'd7] & vld_q[s + 6'd7];
        c_idx  = 3'd6 - carry_cnt;
        c_ok   = end_q[c_idx] & vld_q[c_idx];
        c_data = carry | (data_q[47:0] << {carry_cnt, 3'b000});
    end

    // Two register stages: the scan result lands in p_*, the outputs one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            vld_q      <= '0;
            end_q      <= '0;
            pend       <= '0;
            carry      <= '0;
            carry_cnt  <= '0;
            carry_pend <= 1'b0;
            p_valid    <= 1'b0;
            p_err      <= 1'b0;
            p_data     <= '0;
            dllp_data  <= '0;
            dllp_valid <= 1'b0;
            dllp_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            p_valid    <= 1'b0;
            p_err      <= 1'b0;
            dllp_valid <= linkup & p_valid;
            dllp_err   <= linkup & p_err;
            if (linkup && p_valid) dllp_data <= p_data;
            if (linkup && p_err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
            if (!linkup) begin
                state      <= IDLE;
                pend       <= '0;
                carry      <= '0;
                carry_cnt  <= '0;
                carry_pend <= 1'b0;
            end else if (state == IDLE) begin
                if (bus.in_valid) begin
                    data_q <= bus.data_in;
                    vld_q  <= bus.pl_valid;
                    end_q  <= bus.pl_dlpend;
                    pend   <= bus.pl_dlpstart & bus.pl_valid;
                    state  <= SCAN;
                end
            end else if (carry_pend) begin
                carry_pend <= 1'b0;
                carry      <= '0;
                p_valid    <= c_ok;
                p_err      <= ~c_ok;
                p_data     <= c_data;
            end else if (hit && s <= 6'd56) begin
                pend    <= pend & (pend - 64'd1);
                p_valid <= end_ok;
                p_err   <= ~end_ok;
                p_data  <= win;
            end else if (hit) begin
                // Tail bytes are parked; later starts in this beat cannot be complete.
                carry      <= win;
                carry_cnt  <= 3'(6'd63 - s);
                carry_pend <= 1'b1;
                pend       <= '0;
                state      <= IDLE;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_dllp_extractor.sv
// tb_dllp_extractor: randomized and directed stimulus against a byte-level DLLP model,
// with a scoreboard monitor comparing every dllp_valid/dllp_err pulse.
module tb_dllp_extractor;
    localparam int W = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic linkup = 1'b0;
    always #5 clk = ~clk;

    dllp_extractor_if #(.ERR_CNT_W(W)) bus ();
    dllp_extractor #(.ERR_CNT_W(W)) dut (.clk(clk), .rst_n(rst_n), .linkup(linkup), .bus(bus));

    typedef struct {
        bit          is_err;
        logic [47:0] data;
        int          cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  m_cq[$];
    bit          m_carry = 1'b0;
    int          m_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [47:0] last_data = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input bit ok, input logic [47:0] p);
        exp_t e;
        if (!ok) m_cnt = (m_cnt < (1 << W) - 1) ? m_cnt + 1 : m_cnt;
        e.is_err = !ok;
        e.data   = p;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic model_beat(input logic [511:0] d, input logic [63:0] v, input logic [63:0] st,
                              input logic [63:0] en);
        logic [47:0] p;
        int need;
        if (m_carry) begin
            need = 6 - m_cq.size();
            p = '0;
            for (int i = 0; i < m_cq.size(); i++) p[8*i +: 8] = m_cq[i];
            for (int i = 0; i < need; i++) p[8*(m_cq.size()+i) +: 8] = d[8*i +: 8];
            push(en[need] && v[need], p);
            m_carry = 1'b0;
            m_cq.delete();
        end
        for (int s = 0; s < 64; s++) begin
            if (st[s] && v[s]) begin
                if (s <= 56) begin
                    for (int i = 0; i < 6; i++) p[8*i +: 8] = d[8*(s+1+i) +: 8];
                    push(en[s+7] && v[s+7], p);
                end else begin
                    for (int i = s + 1; i < 64; i++) m_cq.push_back(d[8*i +: 8]);
                    m_carry = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic send(input logic [511:0] d, input logic [63:0] v, input logic [63:0] st,
                        input logic [63:0] en);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            check("ready_timeout", bus.in_ready, 1);
            return;
        end
        bus.in_valid    = 1'b1;
        bus.data_in     = d;
        bus.pl_valid    = v;
        bus.pl_dlpstart = st;
        bus.pl_dlpend   = en;
        model_beat(d, v, st, en);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            last_data = '0;
        end else if (bus.dllp_valid || bus.dllp_err) begin
            check("exclusive", bus.dllp_valid & bus.dllp_err, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {bus.dllp_valid, bus.dllp_err}, 0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", bus.dllp_err, e.is_err);
                if (!e.is_err) begin
                    check("dllp_data", bus.dllp_data, e.data);
                    last_data = e.data;
                end
                check("err_cnt", bus.err_cnt, e.cnt);
            end
        end else begin
            check("hold", bus.dllp_data, last_data);
        end
    end

    initial begin
        logic [511:0] d;
        logic [63:0] v, st, en;
        int s;
        int sat_exp[4] = '{2, 3, 3, 3};
        bus.in_valid    = 1'b0;
        bus.data_in     = '0;
        bus.pl_valid    = '0;
        bus.pl_dlpstart = '0;
        bus.pl_dlpend   = '0;
        idle(3);
        check("rst_dllp_valid", bus.dllp_valid, 0);
        check("rst_dllp_err", bus.dllp_err, 0);
        check("rst_err_cnt", bus.err_cnt, 0);
        check("rst_dllp_data", bus.dllp_data, 0);
        check("rst_ready_l0", bus.in_ready, 0);
        linkup = 1'b1;
        #1 check("rst_ready_l1", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        idle(2);

        d = '0;
        for (int i = 1; i <= 6; i++) d[8*i +: 8] = 8'(i);
        send(d, '1, 64'h1, 64'h80);
        check("lat_n0", bus.dllp_valid, 0);
        idle(1);
        check("lat_n1", bus.dllp_valid, 0);
        idle(1);
        check("lat_n2", bus.dllp_valid, 1);
        check("single_data", bus.dllp_data, 48'h060504030201);
        idle(4);

        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
        send(d, '1, 64'h101, 64'h8080);
        for (int k = 0; k < 3; k++) begin
            check("two_ready_low", bus.in_ready, 0);
            idle(1);
        end
        check("two_ready_back", bus.in_ready, 1);
        idle(4);

        d = '0;
        d[8*61 +: 24] = 24'hCCBBAA;
        send(d, '1, 64'h1 << 60, 64'h0);
        idle(4);
        d = '0;
        d[23:0] = 24'hFFEEDD;
        send(d, '1, 64'h0, 64'h8);
        idle(2);
        check("split_valid", bus.dllp_valid, 1);
        check("split_data", bus.dllp_data, 48'hFFEEDDCCBBAA);
        idle(4);

        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
        send(d, '1, 64'h1, 64'h0);
        idle(2);
        check("malformed_err", bus.dllp_err, 1);
        check("malformed_cnt", bus.err_cnt, 1);
        idle(3);
        for (int k = 0; k < 4; k++) begin
            send(d, '1, 64'h1, 64'h0);
            idle(2);
            check("sat_cnt", bus.err_cnt, sat_exp[k]);
            idle(2);
        end

        d = '0;
        send(d, '1, 64'h1 << 60, 64'h0);
        idle(4);
        linkup = 1'b0;
        #1 check("flush_ready_now", bus.in_ready, 0);
        m_carry = 1'b0;
        m_cq.delete();
        idle(1);
        check("flush_ready_low", bus.in_ready, 0);
        linkup = 1'b1;
        send(d, '1, 64'h0, 64'h8);
        idle(6);
        check("flush_cnt_kept", bus.err_cnt, m_cnt);

        for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
        send(d, '1, 64'h0101_0101, 64'h8080_8080);
        rst_n = 1'b0;
        exp_q.delete();
        m_cq.delete();
        m_carry = 1'b0;
        m_cnt = 0;
        #1 check("midrst_ready", bus.in_ready, 1);
        check("midrst_cnt", bus.err_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        idle(8);

        for (int b = 0; b < 300; b++) begin
            for (int k = 0; k < 16; k++) d[32*k +: 32] = $urandom();
            v  = ($urandom_range(0, 3) == 0) ? ~(64'h1 << $urandom_range(0, 63)) : '1;
            st = '0;
            en = 64'h1 << $urandom_range(0, 63);
            repeat ($urandom_range(0, 3)) begin
                s = $urandom_range(0, 63);
                st[s] = 1'b1;
                if (s <= 56 && $urandom_range(0, 4) != 0) en[s+7] = 1'b1;
            end
            if (m_carry && $urandom_range(0, 4) != 0) en[6-m_cq.size()] = 1'b1;
            send(d, v, st, en);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        idle(10);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dllp_extractor.md
DLLP_EXTRACTOR -- requirements
Module: dllp_extractor

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8, width of the saturating malformed-DLLP counter.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port linkup  input  1  link-up qualifier; low flushes the block.
REQ-005 SHALL have port in_valid  input  1  beat present from packet_identifier (valid_pd domain).
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready at a rising edge.
REQ-007 SHALL have port data_in  input  512  64 bytes; byte k = data_in[8k+7:8k].
REQ-008 SHALL have port pl_valid  input  64  per-byte valid marker.
REQ-009 SHALL have port pl_dlpstart  input  64  per-byte SDP marker.
REQ-010 SHALL have port pl_dlpend  input  64  per-byte DLLP END marker.
REQ-011 SHALL have port dllp_data  output  48  six DLLP bytes; [7:0] = first byte after SDP.
REQ-012 SHALL have port dllp_valid  output  1  one-cycle pulse, dllp_data valid.
REQ-013 SHALL have port dllp_err  output  1  one-cycle pulse, malformed DLLP dropped.
REQ-014 SHALL have port err_cnt  output  ERR_CNT_W  saturating count of dllp_err pulses.

Function
REQ-015 DLLP framing SHALL be 8 bytes: SDP at byte s, payload s+1..s+6, END at s+7, END byte requiring pl_dlpend and pl_valid set.
REQ-016 States SHALL be IDLE and SCAN; in_ready = linkup & (state==IDLE), combinational.
REQ-017 IDLE: on accept, SHALL register data_in, pl_valid, pl_dlpend, and pending mask = pl_dlpstart & pl_valid; go SCAN.
REQ-018 SCAN, carry pending: first cycle SHALL complete the carried DLLP using bytes 0..5-carry_cnt and END at byte 6-carry_cnt; clear carry.
REQ-019 SCAN, no carry: each cycle SHALL process the lowest set bit s of the pending mask and clear it, one DLLP per cycle.
REQ-020 For s<=56: END valid at s+7 -> dllp_valid pulse with payload; otherwise dllp_err pulse, no dllp_valid.
REQ-021 For s>=57: SHALL store bytes s+1..63 in a 48-bit carry register, carry_cnt=63-s (0..6), set carry pending, clear all remaining pending bits, go IDLE.
REQ-022 SCAN with empty pending mask and no carry action SHALL return to IDLE in that cycle.
REQ-023 Latency: beat accepted at edge N -> first dllp_valid/dllp_err visible after edge N+2; outputs registered.
REQ-024 Carry completion SHALL use the next accepted beat regardless of its pending mask; missing END -> dllp_err.
REQ-025 pl_dlpend bits not at an expected END position SHALL be ignored.
REQ-026 dllp_valid and dllp_err SHALL never assert in the same cycle.
REQ-027 err_cnt SHALL increment by 1 per dllp_err pulse and hold at 2^ERR_CNT_W-1.
REQ-028 dllp_data SHALL hold its last value when dllp_valid is low.
REQ-029 linkup low SHALL, at the next edge, force IDLE, clear pending mask and carry, suppress pulses; err_cnt retained.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, clear pending mask, carry, carry_cnt, dllp_data=0, dllp_valid=0, dllp_err=0, err_cnt=0.
REQ-031 During and after reset, in_ready SHALL equal linkup.
REQ-032 rst_n asserted mid-SCAN SHALL abandon all unemitted DLLPs with no pulse.

Verification
REQ-033 Single DLLP: dlpstart bit0, dlpend bit7, bytes1..6=01..06, pl_valid all ones -> one dllp_valid, dllp_data=48'h060504030201, edge N+2.
REQ-034 Two DLLPs: starts at 0 and 8, ends at 7 and 15 -> dllp_valid on two consecutive cycles in order; in_ready low for 3 cycles.
REQ-035 Split: start at 60 (bytes 61..63=AA,BB,CC), next beat bytes 0..2=DD,EE,FF, END at 3 -> dllp_data=48'hFFEEDDCCBBAA, once.
REQ-036 Malformed: start at 0, no dlpend at 7 -> dllp_err one cycle, no dllp_valid, err_cnt 0->1.
REQ-037 Saturation: ERR_CNT_W=2, five malformed DLLPs -> err_cnt sequence 1,2,3,3,3.
REQ-038 Flush: split pending, linkup low one cycle, then beat with END at byte 3 -> no pulse; in_ready low while linkup low.
